// File: rtl/key_sched_gen.sv
// AES-128 key-expansion engine: latches a cipher key on start and then hands out
// round keys 0..10 one at a time over a valid/ready handshake.
module key_sched_gen #(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0][31:0] key_i,
  output logic [3:0][31:0] rk_o,
  output logic [3:0]       rk_idx,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t           state_q;
  logic [3:0][31:0] w_q;
  logic [3:0][31:0] w_d;
  logic [3:0]       idx_q;
  logic [7:0]       rcon_q;
  logic [7:0]       rcon_d;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] t_w;
  logic [31:0] n0_w, n1_w, n2_w, n3_w;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (maps 0 to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x7   = gf_mul(x6, x);
    x14  = gf_mul(x7, x7);
    x15  = gf_mul(x14, x);
    x30  = gf_mul(x15, x15);
    x31  = gf_mul(x30, x);
    x62  = gf_mul(x31, x31);
    x63  = gf_mul(x62, x);
    x126 = gf_mul(x63, x63);
    x127 = gf_mul(x126, x);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  assign rot_w = {w_q[3][23:0], w_q[3][31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub
    assign sub_w[8*gi +: 8] = sbox(rot_w[8*gi +: 8]);
  end

  assign t_w    = sub_w ^ {rcon_q, 24'h000000};
  assign n0_w   = w_q[0] ^ t_w;
  assign n1_w   = w_q[1] ^ n0_w;
  assign n2_w   = w_q[2] ^ n1_w;
  assign n3_w   = w_q[3] ^ n2_w;
  assign w_d    = {n3_w, n2_w, n1_w, n0_w};
  assign rcon_d = xtime(rcon_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            w_q     <= key_i;
            idx_q   <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            valid_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          w_q     <= w_d;
          idx_q   <= idx_q + 4'd1;
          rcon_q  <= rcon_d;
          valid_q <= 1'b1;
          state_q <= EMIT;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rk_o     = w_q;
  assign rk_idx   = idx_q;
  assign rk_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_key_sched_gen.sv
// Bench for key_sched_gen: known-answer vectors, random keys under random
// backpressure against a FIPS-197 key-expansion model, and handshake corner cases.
module tb_key_sched_gen;

  typedef logic [3:0][31:0] key_t;

  typedef struct {
    key_t key;
    int   idx;
    key_t exp;
  } vec_t;

  logic clk;
  logic rst;
  logic start;
  key_t key_i;
  key_t rk_o;
  logic [3:0] rk_idx;
  logic rk_valid;
  logic rk_ready;
  logic busy;
  logic done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb [256];
  key_t got_keys [11];
  int   got_n;
  int   done_cyc;
  int   stall_cnt;

  key_sched_gen #(.NR(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_i    (key_i),
    .rk_o     (rk_o),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic key_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box table built from the generator-3 log walk over GF(2^8).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Textbook expansion into 44 words, then slice out the requested round.
  function automatic key_t model_rk(input key_t k, input int idx);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[i];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0)
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc[i/4 - 1], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*idx+3], w[4*idx+2], w[4*idx+1], w[4*idx]};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is seen by the next edge and we return in cycle 1.
  task automatic issue_start(input key_t k);
    start = 1'b1;
    key_i = k;
    @(negedge clk);
    start = 1'b0;
    key_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_sched(input int pct, input bit inject, input string tag);
    int   cyc;
    key_t prev;
    logic [3:0] prev_idx;
    bit   stalled;
    cyc = 1; got_n = 0; done_cyc = -1; stall_cnt = 0;
    stalled = 1'b0; prev = '0; prev_idx = '0;
    while (cyc < 2000) begin
      if (stalled) begin
        chk("stall_rk_o", rk_o, prev);
        chk("stall_idx", rk_idx, prev_idx);
      end
      if (done) begin
        done_cyc = cyc;
        chk("busy_in_done", busy, 1'b0);
        chk("valid_in_done", rk_valid, 1'b0);
        break;
      end
      chk("busy_during", busy, 1'b1);
      start = inject && (rk_idx == 4'd4);
      if (start) key_i = {$urandom, $urandom, $urandom, $urandom};
      rk_ready = ($urandom_range(99) < pct);
      stalled = 1'b0;
      if (rk_valid) begin
        if (rk_ready) begin
          $display("[%s] cyc=%0d idx=%0d rk=%h", tag, cyc, rk_idx, rk_o);
          if (got_n < 11) begin
            got_keys[got_n] = rk_o;
            chk("xfer_idx", rk_idx, got_n);
          end
          got_n++;
        end else begin
          stalled = 1'b1;
          stall_cnt++;
          prev = rk_o;
          prev_idx = rk_idx;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rk_ready = 1'b0;
    if (done_cyc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, cyc);
    end
    chk("key_count", got_n, 11);
  endtask

  task automatic chk_all(input key_t k, input int upto);
    for (int i = 0; i < upto && i < got_n && i < 11; i++)
      chk("model_key", got_keys[i], model_rk(k, i));
  endtask

  key_t a1;
  key_t zk;
  key_t rk;
  vec_t vecs [5];

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_i = '0;
    build_sbox();
    a1 = mk(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c);
    zk = '0;
    vecs[0] = '{key: a1, idx: 0,  exp: a1};
    vecs[1] = '{key: a1, idx: 1,  exp: mk(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605)};
    vecs[2] = '{key: a1, idx: 10, exp: mk(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6)};
    vecs[3] = '{key: zk, idx: 1,  exp: mk(32'h62636363, 32'h62636363, 32'h62636363, 32'h62636363)};
    vecs[4] = '{key: zk, idx: 2,  exp: mk(32'h9b9898c9, 32'hf9fbfbaa, 32'h9b9898c9, 32'hf9fbfbaa)};

    repeat (3) @(negedge clk);
    chk("rst_rk_o", rk_o, '0);
    chk("rst_idx", rk_idx, 4'd0);
    chk("rst_valid", rk_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      issue_start(vecs[v].key);
      run_sched(100, 1'b0, "kat");
      chk("kat_key", got_keys[vecs[v].idx], vecs[v].exp);
      chk("kat_done_cycle", done_cyc, 22);
      chk_all(vecs[v].key, 11);
      @(negedge clk);
    end

    for (int r = 0; r < 4; r++) begin
      rk = (r == 0) ? a1 : key_t'({$urandom, $urandom, $urandom, $urandom});
      issue_start(rk);
      run_sched(30, 1'b0, "bp");
      chk_all(rk, 11);
      chk("bp_done_cycle", done_cyc, 22 + stall_cnt);
      @(negedge clk);
    end

    issue_start(a1);
    run_sched(100, 1'b1, "inj");
    chk_all(a1, 11);
    chk("inj_done_cycle", done_cyc, 22);
    @(negedge clk);

    issue_start(a1);
    rk_ready = 1'b1;
    guard = 0;
    while (!(rk_valid && rk_idx == 4'd6) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_idx6", rk_idx, 4'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rk_ready = 1'b0;
    chk("mid_rst_rk_o", rk_o, '0);
    chk("mid_rst_idx", rk_idx, 4'd0);
    chk("mid_rst_valid", rk_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    @(negedge clk);
    chk("post_rst_valid", rk_valid, 1'b0);
    issue_start(a1);
    chk("post_rst_first_valid", rk_valid, 1'b1);
    run_sched(100, 1'b0, "rst");
    chk("post_rst_k0", got_keys[0], a1);
    chk("post_rst_k1", got_keys[1], vecs[1].exp);

    @(negedge clk);
    issue_start(a1);
    run_sched(100, 1'b0, "b2b_a");
    chk_all(a1, 11);
    issue_start(zk);
    chk("b2b_first_valid", rk_valid, 1'b1);
    run_sched(100, 1'b0, "b2b_z");
    chk("b2b_k0", got_keys[0], zk);
    chk("b2b_k2", got_keys[2], vecs[4].exp);
    chk("b2b_done_cycle", done_cyc, 22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
